// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory between two
// requesters (A = CPU, B = loader/DMA). Each access runs IDLE -> ACCESS -> RESP,
// winners are chosen round-robin or with fixed A priority, and word indices at
// or beyond MEM_WORDS are rejected without touching the memory.
module mem_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iReqA,
    input  logic        iWriteA,
    input  logic [31:0] iAddrA,
    input  logic [31:0] iDataA,
    output logic        oAckA,
    output logic        oErrA,
    output logic [31:0] oDataA,
    input  logic        iReqB,
    input  logic        iWriteB,
    input  logic [31:0] iAddrB,
    input  logic [31:0] iDataB,
    output logic        oAckB,
    output logic        oErrB,
    output logic [31:0] oDataB,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        take;        // IDLE edge accepts a request this cycle
    logic        grant_b;     // winner of the current IDLE evaluation is B
    logic        last_b;      // last access that reached RESP belonged to B
    logic        win_b;       // owner of the access in flight
    logic        lat_wr;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic        sel_wr;
    logic [31:0] resp_data;
    logic [31:0] hold_a;
    logic [31:0] hold_b;

    // Next-state and arbitration decision; requests only matter in IDLE.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        grant_b   = 1'b0;
        case (state)
            IDLE: begin
                if (iReqA || iReqB) begin
                    take = 1'b1;
                    // On a tie, round-robin hands B the grant only when A went last.
                    grant_b   = iReqB && (!iReqA || (!FIXED_PRI && !last_b));
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's controls, muxed ahead of the memory-side registers.
    always_comb begin
        sel_addr = grant_b ? iAddrB  : iAddrA;
        sel_data = grant_b ? iDataB  : iDataA;
        sel_wr   = grant_b ? iWriteB : iWriteA;
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge iClk) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Memory-side latches, winner record and last-grant tracking.
    always_ff @(posedge iClk) begin
        if (!nRst) begin
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            lat_err  <= 1'b0;
            win_b    <= 1'b0;
            last_b   <= 1'b1;  // pretend B went last so A wins the first tie
        end else begin
            if (take) begin
                lat_addr <= sel_addr;
                lat_data <= sel_data;
                lat_wr   <= sel_wr;
                lat_err  <= (sel_addr[31:2] >= 30'(MEM_WORDS));
                win_b    <= grant_b;
            end
            // Last-grant moves only once the access is committed to RESP.
            if (state == ACCESS) last_b <= win_b;
        end
    end

    // Read data is only meaningful for an in-range read.
    always_comb begin
        resp_data = (lat_wr || lat_err) ? 32'h0 : iMemData;
    end

    // Per-port data-hold registers capture the RESP value of their own access.
    always_ff @(posedge iClk) begin
        if (!nRst) begin
            hold_a <= '0;
            hold_b <= '0;
        end else if (state == RESP) begin
            if (win_b) hold_b <= resp_data;
            else       hold_a <= resp_data;
        end
    end

    // Memory strobes and requester responses decoded from state.
    always_comb begin
        oMemAddr  = lat_addr;
        oMemData  = lat_data;
        oMemRead  = (state == ACCESS) && !lat_wr && !lat_err;
        oMemWrite = (state == ACCESS) &&  lat_wr && !lat_err;
        oAckA     = (state == RESP) && !win_b;
        oAckB     = (state == RESP) &&  win_b;
        oErrA     = oAckA && lat_err;
        oErrB     = oAckB && lat_err;
        oDataA    = oAckA ? resp_data : hold_a;
        oDataB    = oAckB ? resp_data : hold_b;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter, with a round-robin
// instance on a behavioural memory and a fixed-priority instance for tie tests.
module tb_mem_arbiter;

    logic        iClk = 1'b0;
    logic        nRst;
    logic        iReqA, iWriteA, iReqB, iWriteB;
    logic [31:0] iAddrA, iDataA, iAddrB, iDataB;
    logic        oAckA, oErrA, oAckB, oErrB;
    logic [31:0] oDataA, oDataB;
    logic        oMemRead, oMemWrite;
    logic [31:0] oMemAddr, oMemData;
    logic [31:0] iMemData;

    logic        fReqA, fReqB;
    logic        fAckA, fErrA, fAckB, fErrB;
    logic [31:0] fDataA, fDataB;
    logic        fMemRead, fMemWrite;
    logic [31:0] fMemAddr, fMemData;
    logic [31:0] fMemIn;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_data;

    typedef struct packed {
        logic        port;   // 0 = A, 1 = B
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    always #5 iClk = ~iClk;

    mem_arbiter #(.MEM_WORDS(1024), .FIXED_PRI(1'b0)) dut (
        .iClk(iClk), .nRst(nRst),
        .iReqA(iReqA), .iWriteA(iWriteA), .iAddrA(iAddrA), .iDataA(iDataA),
        .oAckA(oAckA), .oErrA(oErrA), .oDataA(oDataA),
        .iReqB(iReqB), .iWriteB(iWriteB), .iAddrB(iAddrB), .iDataB(iDataB),
        .oAckB(oAckB), .oErrB(oErrB), .oDataB(oDataB),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr),
        .oMemData(oMemData), .iMemData(iMemData)
    );

    mem_arbiter #(.MEM_WORDS(1024), .FIXED_PRI(1'b1)) dut_fp (
        .iClk(iClk), .nRst(nRst),
        .iReqA(fReqA), .iWriteA(1'b0), .iAddrA(32'h0), .iDataA(32'h0),
        .oAckA(fAckA), .oErrA(fErrA), .oDataA(fDataA),
        .iReqB(fReqB), .iWriteB(1'b0), .iAddrB(32'h4), .iDataB(32'h0),
        .oAckB(fAckB), .oErrB(fErrB), .oDataB(fDataB),
        .oMemRead(fMemRead), .oMemWrite(fMemWrite), .oMemAddr(fMemAddr),
        .oMemData(fMemData), .iMemData(fMemIn)
    );

    assign fMemIn = 32'h0;

    // Behavioural 1024x32 memory with registered read and a backdoor loader.
    always @(posedge iClk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        if (oMemWrite) mem[oMemAddr[11:2]] <= oMemData;
        if (oMemRead) iMemData <= mem[oMemAddr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected response.
    always @(negedge iClk) begin
        exp_t e;
        if (oAckA || oAckB) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'h0, oAckA, oAckB}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {30'h0, oAckA, oAckB}, e.port ? 32'h1 : 32'h2);
                chk("ack_err", 32'(e.port ? oErrB : oErrA), 32'(e.err));
                chk("ack_data", e.port ? oDataB : oDataA, e.data);
            end
        end
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        @(negedge iClk);
        bd_we = 1'b1; bd_idx = idx; bd_data = d;
        @(negedge iClk);
        bd_we = 1'b0;
    endtask

    task automatic run_access(input logic port, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic err, input logic [31:0] edata);
        int lat;
        lat = 0;
        sb.push_back(exp_t'{port: port, err: err, data: edata});
        @(negedge iClk);
        if (!port) begin iReqA = 1'b1; iWriteA = wr; iAddrA = addr; iDataA = data; end
        else       begin iReqB = 1'b1; iWriteB = wr; iAddrB = addr; iDataB = data; end
        for (int c = 1; c <= 8; c++) begin
            @(negedge iClk);
            if (c == 1) begin
                chk("access_rd", 32'(oMemRead), 32'(!wr && !err));
                chk("access_wr", 32'(oMemWrite), 32'(wr && !err));
                chk("access_addr", oMemAddr, addr);
            end
            if (port ? oAckB : oAckA) begin
                lat = c;
                break;
            end
        end
        iReqA = 1'b0; iReqB = 1'b0;
        chk("latency", 32'(lat), 32'd2);
    endtask

    task automatic pulse_reset();
        @(negedge iClk);
        nRst = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        nRst = 1'b1;
    endtask

    initial begin
        int t[4];
        int n;
        int ca, cb;
        logic [1:0] first;
        nRst = 1'b0;
        iReqA = 1'b0; iWriteA = 1'b0; iAddrA = '0; iDataA = '0;
        iReqB = 1'b0; iWriteB = 1'b0; iAddrB = '0; iDataB = '0;
        fReqA = 1'b0; fReqB = 1'b0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;

        // Reset state.
        repeat (3) @(negedge iClk);
        chk("rst_ackA", 32'(oAckA), 32'h0);
        chk("rst_ackB", 32'(oAckB), 32'h0);
        chk("rst_errA", 32'(oErrA), 32'h0);
        chk("rst_dataA", oDataA, 32'h0);
        chk("rst_dataB", oDataB, 32'h0);
        chk("rst_memrd", 32'(oMemRead), 32'h0);
        chk("rst_memwr", 32'(oMemWrite), 32'h0);
        chk("rst_memaddr", oMemAddr, 32'h0);
        chk("rst_memdata", oMemData, 32'h0);
        nRst = 1'b1;

        // A reads word 4.
        preload(10'd4, 32'hDEADBEEF);
        preload(10'd0, 32'h0BADF00D);
        run_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEADBEEF);
        @(negedge iClk);
        chk("holdA_after_read", oDataA, 32'hDEADBEEF);

        // B writes 0x150, then A reads it back.
        run_access(1'b1, 1'b1, 32'h0000_0150, 32'h0000_0047, 1'b0, 32'h0);
        chk("mem_0x54", mem[10'h54], 32'h0000_0047);
        run_access(1'b0, 1'b0, 32'h0000_0150, 32'h0, 1'b0, 32'h0000_0047);
        @(negedge iClk);
        @(negedge iClk);
        chk("holdA_0x47", oDataA, 32'h0000_0047);
        chk("holdB_zero", oDataB, 32'h0);

        // Round-robin with both held high: A,B,A,B spaced 3 cycles.
        pulse_reset();
        sb.push_back(exp_t'{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
        sb.push_back(exp_t'{port: 1'b1, err: 1'b0, data: 32'h0000_0047});
        sb.push_back(exp_t'{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
        sb.push_back(exp_t'{port: 1'b1, err: 1'b0, data: 32'h0000_0047});
        @(negedge iClk);
        iReqA = 1'b1; iWriteA = 1'b0; iAddrA = 32'h10;
        iReqB = 1'b1; iWriteB = 1'b0; iAddrB = 32'h150;
        n = 0;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            @(negedge iClk);
            if (oAckA || oAckB) begin
                t[n] = c;
                n++;
            end
        end
        iReqA = 1'b0; iReqB = 1'b0;
        chk("rr_ack_count", 32'(n), 32'd4);
        if (n == 4) begin
            chk("rr_gap1", 32'(t[1] - t[0]), 32'd3);
            chk("rr_gap2", 32'(t[2] - t[1]), 32'd3);
            chk("rr_gap3", 32'(t[3] - t[2]), 32'd3);
        end

        // Out-of-range write: no strobe, error ack, memory untouched.
        run_access(1'b0, 1'b1, 32'h0000_1000, 32'h0000_1234, 1'b1, 32'h0);
        @(negedge iClk);
        chk("oor_mem0", mem[10'h0], 32'h0BADF00D);
        chk("oor_holdA", oDataA, 32'h0);

        // Reset during the ACCESS of a B write.
        @(negedge iClk);
        iReqB = 1'b1; iWriteB = 1'b1; iAddrB = 32'h8; iDataB = 32'h55;
        @(negedge iClk);
        chk("abort_wr_active", 32'(oMemWrite), 32'h1);
        nRst = 1'b0;
        @(negedge iClk);
        chk("abort_wr_drop", 32'(oMemWrite), 32'h0);
        chk("abort_no_ackB", 32'(oAckB), 32'h0);
        iReqB = 1'b0; iWriteB = 1'b0;
        nRst = 1'b1;
        cb = 0;
        repeat (4) begin
            @(negedge iClk);
            if (oAckB) cb++;
        end
        chk("abort_ackB_count", 32'(cb), 32'h0);
        sb.push_back(exp_t'{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
        iReqA = 1'b1; iWriteA = 1'b0; iAddrA = 32'h10;
        iReqB = 1'b1; iWriteB = 1'b0; iAddrB = 32'h150;
        first = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge iClk);
            if (oAckA || oAckB) begin
                first = {oAckA, oAckB};
                break;
            end
        end
        iReqA = 1'b0; iReqB = 1'b0;
        chk("tie_after_reset", 32'(first), 32'h2);

        // Fixed priority: A wins every tie while it keeps requesting.
        @(negedge iClk);
        fReqA = 1'b1; fReqB = 1'b1;
        ca = 0; cb = 0;
        repeat (9) begin
            @(negedge iClk);
            if (fAckA) ca++;
            if (fAckB) cb++;
        end
        fReqA = 1'b0;
        chk("fp_ackA_count", 32'(ca), 32'd3);
        chk("fp_ackB_count", 32'(cb), 32'd0);
        cb = 0;
        repeat (6) begin
            @(negedge iClk);
            if (fAckB) cb++;
        end
        fReqB = 1'b0;
        chk("fp_ackB_alone", 32'(cb), 32'd2);

        repeat (4) @(negedge iClk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
